mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data RAM between the instruction-fetch and load/store ports of the RISC-V core inside `riscv_min_sopc`. It serialises requests through a small FSM, grants the data port over the fetch port, and produces per-port stall requests for the pipeline control unit. It also hides the RAM's fixed read latency behind a one-cycle ready pulse.

## Interface
- `READ_LAT`, 2: RAM read latency in cycles from the ce-sampling edge to valid `ram_rdata`; legal range ≥1.
- `RAM_AW`, 17: RAM word-address width; `ram_addr = addr[RAM_AW+1:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-low**; rst==0 resets.
- `if_req` in 1: fetch read request, held until `if_ready`.
- `if_addr` in 32: fetch byte address, word aligned.
- `if_rdata` out 32: fetched word, valid while `if_ready`=1.
- `if_ready` out 1: one-cycle completion pulse.
- `mem_req` in 1: load/store request, held until `mem_ready`.
- `mem_we` in 1: 1=store, 0=load.
- `mem_sel` in 4: byte lanes for stores.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: load data, valid while `mem_ready`=1.
- `mem_ready` out 1: one-cycle completion pulse.
- `stall_if` out 1: `if_req & ~if_ready` (combinational).
- `stall_mem` out 1: `mem_req & ~mem_ready` (combinational).
- `ram_ce` out 1: RAM access strobe, one cycle per access.
- `ram_we` out 1: RAM write enable.
- `ram_sel` out 4: RAM byte lanes (4'b1111 for reads).
- `ram_addr` out RAM_AW: RAM word address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests sampled only here.
  - `mem_req` wins over `if_req` (fixed priority; the older instruction must drain).
  - On a grant, latch owner, we, sel, addr and wdata; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: `ram_ce`=1 and the `ram_*` outputs carry the latched values for exactly one cycle.
  - Write: go to RESP.
  - Read: load counter with READ_LAT-1 and go to WAIT.
- WAIT: counter decrements each cycle. When the counter is 0, capture `ram_rdata` into the owner's rdata register and go to RESP.
  - Counter width is `$clog2(READ_LAT+1)`.
  - READ_LAT=1 passes through WAIT once, with count already 0.
- RESP: owner's ready=1 for one cycle, then IDLE.
  - A request still high during RESP belongs to the completed transfer and is ignored.
  - A request still high in the following IDLE cycle is a new transfer.
- rdata registers hold their last value until overwritten. The non-owner's rdata is never modified.
- Stores never touch `mem_rdata`.
- Reset (async, any state): FSM→IDLE; all outputs 0, including `if_rdata`, `mem_rdata`, `ram_*` and ready; counter 0; an in-flight RAM read is discarded and produces no ready pulse.
- Address bits [1:0] and [31:RAM_AW+2] are ignored; no misalignment checking.

## Timing
- Request visible at edge E0 (IDLE): `ram_ce` high in the cycle after E0.
- Read: ready high READ_LAT+2 cycles after the request cycle. With default READ_LAT=2: request in cycle 0, ready in cycle 4.
- Write: ready high 2 cycles after the request cycle.
- Back-to-back accesses from one requester: one idle (IDLE) cycle between RESP and the next ISSUE.
  - Read throughput: one access per READ_LAT+3 cycles.
- Simultaneous `if_req` and `mem_req` in IDLE: data access first; fetch granted in the next IDLE.
- Fetch waits at most one data transfer.
- `stall_*` react combinationally within the cycle a request rises.

## Structure
- State encodings (2-bit) and `READ_LAT` default go in the shared `defines.v` alongside the existing global macros. The reset-active value follows the codebase macros, adapted for active-low.
- One flat module, no sub-module; the latency counter is inline.

## Test plan
- Single fetch, READ_LAT=2, `if_addr`=0x0000_0010, RAM word 4 = 0x0010_0093:
  - `ram_ce` in cycle 1 with `ram_addr`=4.
  - `if_ready`=1 and `if_rdata`=0x0010_0093 in cycle 4.
  - `stall_if`=1 in cycles 0–3.
- Store `mem_addr`=0x20, `mem_sel`=4'b0011, `mem_wdata`=0xDEAD_BEEF:
  - `ram_we`=1, `ram_sel`=0011, `ram_addr`=8 in cycle 1.
  - `mem_ready` in cycle 2.
  - `mem_rdata` unchanged.
- Simultaneous fetch (0x0) and load (0x40) in cycle 0:
  - Load ISSUE in cycle 1, `mem_ready` in cycle 4.
  - Fetch ISSUE in cycle 6, `if_ready` in cycle 9.
  - `stall_if` high in cycles 0–8.
- Continuous `if_req` over addresses 0,4,8:
  - ready pulses in cycles 4, 9, 14.
  - No request is issued from a RESP cycle.
- Reset pulse (`rst`=0) asserted mid-WAIT:
  - All outputs 0 immediately.
  - No ready pulse after release.
  - A new fetch after release completes in 4 cycles.
- Sweep READ_LAT ∈ {1,3}: read ready in cycles 3 and 5 respectively, with correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    localparam int         READ_LAT_DEFAULT = 2;
    localparam logic       RST_ACTIVE       = 1'b0;
    localparam logic [3:0] SEL_ALL          = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, data port
// first, hiding the fixed RAM read latency behind a one-cycle ready pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEFAULT,
    parameter int RAM_AW   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int               CNT_W    = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    arb_state_e        state, state_nxt;
    arb_owner_e        owner_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;
    logic              unused_addr_bits;

    // Address bits outside the RAM word window are deliberately ignored.
    assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                                mem_addr[31:RAM_AW+2], mem_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_sel   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req || if_req) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                ram_ce    = 1'b1;
                ram_we    = we_q;
                ram_sel   = sel_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                state_nxt = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if_ready  = (owner_q == OWN_IF);
                mem_ready = (owner_q == OWN_MEM);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Requests are latched only in IDLE; the data port wins so older loads/stores drain.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        owner_q <= OWN_MEM;
                        we_q    <= mem_we;
                        sel_q   <= mem_we ? mem_sel : SEL_ALL;
                        addr_q  <= mem_addr[RAM_AW+1:2];
                        wdata_q <= mem_wdata;
                    end else if (if_req) begin
                        owner_q <= OWN_IF;
                        we_q    <= 1'b0;
                        sel_q   <= SEL_ALL;
                        addr_q  <= if_addr[RAM_AW+1:2];
                        wdata_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (!we_q) cnt_q <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_MEM) mem_rdata_q <= ram_rdata;
                        else                    if_rdata_q  <= ram_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule
